psum_drain: RTL and testbench

- Consumer end of the accumulator result interface: takes per-kernel accumulated psums and their valid strobes, buffers them per kernel, and serializes them onto one valid/ready output stream tagged with the kernel index.
- Sits between the psum accumulator and the output feature-map writeback buffer.
- Absorbs results that complete in the same cycle and applies back-pressure isolation, so the accumulator never stalls.

---
 rtl/psum_drain.sv | 153 +++++++++++++++
 tb/tb_psum_drain.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/psum_drain.sv
// psum_drain: buffers per-kernel accumulator results and serializes them round-robin onto one valid/ready stream.
// Define PSUM_DRAIN_RELU_EN to clamp negative psums to zero on the output; otherwise data passes bit-exact.
module psum_drain #(
  parameter int BIT_WIDTH  = 8,
  parameter int NUM_KERNEL = 4,
  parameter int REG_WIDTH  = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_WIDTH-1:0]  i_conf_knmask,
  input  logic [BIT_WIDTH-1:0]  i_psum_kn0,
  input  logic [BIT_WIDTH-1:0]  i_psum_kn1,
  input  logic [BIT_WIDTH-1:0]  i_psum_kn2,
  input  logic [BIT_WIDTH-1:0]  i_psum_kn3,
  input  logic                  i_psum_kn0_val,
  input  logic                  i_psum_kn1_val,
  input  logic                  i_psum_kn2_val,
  input  logic                  i_psum_kn3_val,
  input  logic                  i_err_clr,
  input  logic                  i_out_rdy,
  output logic [BIT_WIDTH-1:0]  o_out_data,
  output logic [1:0]            o_out_kn,
  output logic                  o_out_val,
  output logic [NUM_KERNEL-1:0] o_ovf,
  output logic                  o_busy,
  output logic [REG_WIDTH-1:0]  o_drain_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int KW = $clog2(NUM_KERNEL);

  logic [BIT_WIDTH-1:0]  psum_in [NUM_KERNEL];
  logic [NUM_KERNEL-1:0] psum_val;
  logic [NUM_KERNEL-1:0] kn_mask;
  logic                  unused_mask_hi;

  logic [BIT_WIDTH-1:0]  fifo_mem [NUM_KERNEL][FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr [NUM_KERNEL];
  logic [PW-1:0]         rd_ptr [NUM_KERNEL];
  logic [NUM_KERNEL-1:0] fifo_empty;
  logic [NUM_KERNEL-1:0] fifo_full;
  logic [NUM_KERNEL-1:0] push;
  logic [NUM_KERNEL-1:0] pop;
  logic [NUM_KERNEL-1:0] ovf_set;

  logic [KW-1:0]         rr_ptr;
  logic [KW-1:0]         grant;
  logic [KW-1:0]         idx;
  logic                  found;
  logic                  load;
  logic [BIT_WIDTH-1:0]  rd_word;
  logic [BIT_WIDTH-1:0]  out_word;

  assign psum_in[0] = i_psum_kn0;
  assign psum_in[1] = i_psum_kn1;
  assign psum_in[2] = i_psum_kn2;
  assign psum_in[3] = i_psum_kn3;
  assign psum_val   = {i_psum_kn3_val, i_psum_kn2_val, i_psum_kn1_val, i_psum_kn0_val};
  assign kn_mask    = i_conf_knmask[NUM_KERNEL-1:0];
  assign unused_mask_hi = ^i_conf_knmask[REG_WIDTH-1:NUM_KERNEL];

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  always_comb begin
    for (int k = 0; k < NUM_KERNEL; k++) begin
      fifo_empty[k] = (wr_ptr[k] == rd_ptr[k]);
      fifo_full[k]  = (wr_ptr[k][AW] != rd_ptr[k][AW]) &&
                      (wr_ptr[k][AW-1:0] == rd_ptr[k][AW-1:0]);
    end
  end

  always_comb begin
    grant = rr_ptr;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_KERNEL; i++) begin
      idx = rr_ptr + KW'(i);
      if (!found && !fifo_empty[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  assign load    = (!o_out_val || i_out_rdy) && found;
  assign rd_word = fifo_mem[grant][rd_ptr[grant][AW-1:0]];

`ifdef PSUM_DRAIN_RELU_EN
  assign out_word = rd_word[BIT_WIDTH-1] ? '0 : rd_word;
`else
  assign out_word = rd_word;
`endif

  // A full FIFO still accepts a push when it is being popped in the same cycle.
  always_comb begin
    for (int k = 0; k < NUM_KERNEL; k++) begin
      pop[k]     = load && (grant == KW'(k));
      push[k]    = psum_val[k] && kn_mask[k] && (!fifo_full[k] || pop[k]);
      ovf_set[k] = psum_val[k] && kn_mask[k] && fifo_full[k] && !pop[k];
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_KERNEL; k++) begin
      if (push[k]) fifo_mem[k][wr_ptr[k][AW-1:0]] <= psum_in[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_KERNEL; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_KERNEL; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + PW'(1);
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_out_val  <= 1'b0;
      o_out_data <= '0;
      o_out_kn   <= '0;
      rr_ptr     <= KW'(NUM_KERNEL - 1);
    end else if (load) begin
      o_out_val  <= 1'b1;
      o_out_data <= out_word;
      o_out_kn   <= grant;
      rr_ptr     <= grant;
    end else if (i_out_rdy) begin
      o_out_val  <= 1'b0;
    end
  end

  // New overflow takes precedence over a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_ovf       <= '0;
      o_drain_cnt <= '0;
    end else begin
      o_ovf <= (i_err_clr ? '0 : o_ovf) | ovf_set;
      if (o_out_val && i_out_rdy) o_drain_cnt <= o_drain_cnt + REG_WIDTH'(1);
    end
  end

  assign o_busy = !(&fifo_empty) || o_out_val;

endmodule

// File: tb/tb_psum_drain.sv
// Directed self-checking bench for psum_drain with hand-computed expected values.
// RELU expectations follow PSUM_DRAIN_RELU_EN when it is defined for the build.
module tb_psum_drain;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] conf_knmask = 32'hF;
  logic [7:0]  psum [4];
  logic [3:0]  sval = 4'h0;
  logic        err_clr = 1'b0;
  logic        out_rdy = 1'b1;
  logic [7:0]  out_data;
  logic [1:0]  out_kn;
  logic        out_val;
  logic [3:0]  ovf;
  logic        busy;
  logic [31:0] drain_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  psum_drain dut (
    .clk(clk), .rst(rst), .i_conf_knmask(conf_knmask),
    .i_psum_kn0(psum[0]), .i_psum_kn1(psum[1]), .i_psum_kn2(psum[2]), .i_psum_kn3(psum[3]),
    .i_psum_kn0_val(sval[0]), .i_psum_kn1_val(sval[1]),
    .i_psum_kn2_val(sval[2]), .i_psum_kn3_val(sval[3]),
    .i_err_clr(err_clr), .i_out_rdy(out_rdy),
    .o_out_data(out_data), .o_out_kn(out_kn), .o_out_val(out_val),
    .o_ovf(ovf), .o_busy(busy), .o_drain_cnt(drain_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sval = 4'h0;
    err_clr = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic strobe(input int k, input logic [7:0] d);
    psum[k] = d;
    sval = 4'h0;
    sval[k] = 1'b1;
  endtask

  initial begin
    int beats;
    logic [7:0] relu_exp;
    for (int k = 0; k < 4; k++) psum[k] = 8'h00;

    // reset held with strobes toggling
    for (int c = 0; c < 4; c++) begin
      sval = 4'(c + 5);
      psum[0] = 8'(c * 17 + 3);
      tick();
    end
    check_eq("rst_val", 32'(out_val), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'd0);
    check_eq("rst_kn", 32'(out_kn), 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_cnt", drain_cnt, 32'd0);
    sval = 4'h0;
    rst = 1'b1;
    tick(); tick();
    check_eq("idle_val", 32'(out_val), 32'd0);
    check_eq("idle_busy", 32'(busy), 32'd0);

    // single word
    do_reset();
    conf_knmask = 32'hF; out_rdy = 1'b1;
    strobe(2, 8'h35);
    tick();
    sval = 4'h0;
    check_eq("single_nobypass", 32'(out_val), 32'd0);
    check_eq("single_busy", 32'(busy), 32'd1);
    tick();
    check_eq("single_val", 32'(out_val), 32'd1);
    check_eq("single_data", 32'(out_data), 32'h35);
    check_eq("single_kn", 32'(out_kn), 32'd2);
    tick();
    check_eq("single_done", 32'(out_val), 32'd0);
    check_eq("single_cnt", drain_cnt, 32'd1);

    // simultaneous results
    do_reset();
    psum[0] = 8'h10; psum[1] = 8'h20; psum[2] = 8'h30; psum[3] = 8'h40;
    sval = 4'hF;
    tick();
    sval = 4'h0;
    for (int b = 0; b < 4; b++) begin
      tick();
      check_eq($sformatf("simul_val%0d", b), 32'(out_val), 32'd1);
      check_eq($sformatf("simul_kn%0d", b), 32'(out_kn), 32'(b));
      check_eq($sformatf("simul_data%0d", b), 32'(out_data), 32'(8'h10 * (b + 1)));
    end
    tick();
    check_eq("simul_done", 32'(out_val), 32'd0);
    check_eq("simul_cnt", drain_cnt, 32'd4);

    // back-pressure and overflow
    do_reset();
    out_rdy = 1'b0;
    for (int w = 1; w <= 4; w++) begin
      strobe(1, 8'(w));
      tick();
    end
    sval = 4'h0;
    check_eq("bp_val", 32'(out_val), 32'd1);
    check_eq("bp_data", 32'(out_data), 32'h01);
    check_eq("bp_kn", 32'(out_kn), 32'd1);
    check_eq("bp_ovf", 32'(ovf), 32'h2);
    tick(); tick();
    check_eq("bp_hold", 32'(out_data), 32'h01);
    check_eq("bp_hold_val", 32'(out_val), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("bp_clr", 32'(ovf), 32'd0);
    strobe(1, 8'h05);
    err_clr = 1'b1;
    tick();
    sval = 4'h0;
    check_eq("bp_ovf_wins", 32'(ovf), 32'h2);
    tick();
    err_clr = 1'b0;
    check_eq("bp_clr2", 32'(ovf), 32'd0);
    out_rdy = 1'b1;
    strobe(1, 8'h06);
    tick();
    sval = 4'h0;
    check_eq("bp_fullpp_ovf", 32'(ovf), 32'd0);
    check_eq("bp_d02", 32'(out_data), 32'h02);
    tick();
    check_eq("bp_d03", 32'(out_data), 32'h03);
    tick();
    check_eq("bp_d06", 32'(out_data), 32'h06);
    check_eq("bp_v06", 32'(out_val), 32'd1);
    tick();
    check_eq("bp_done", 32'(out_val), 32'd0);
    check_eq("bp_cnt", drain_cnt, 32'd4);

    // mask and fairness
    do_reset();
    conf_knmask = 32'h5; out_rdy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 4; k++) psum[k] = 8'(8'h10 * k + c);
      sval = 4'hF;
      tick();
      if (c >= 1) begin
        check_eq($sformatf("fair_kn%0d", c - 1), 32'(out_kn), (c % 2 == 1) ? 32'd0 : 32'd2);
        if (c <= 4) check_eq($sformatf("fair_data%0d", c - 1), 32'(out_data),
                             32'(((c % 2 == 1) ? 8'h00 : 8'h20) + ((c - 1) / 2)));
      end
    end
    sval = 4'h0;
    tick();
    check_eq("fair_kn7", 32'(out_kn), 32'd2);
    check_eq("fair_ovf", 32'(ovf), 32'h5);
    conf_knmask = 32'h0;
    beats = 0;
    for (int c = 0; c < 20 && beats < 10; c++) begin
      tick();
      if (out_val) beats++;
      else break;
    end
    check_eq("mask_drain_beats", 32'(beats), 32'd3);
    check_eq("mask_drain_busy", 32'(busy), 32'd0);

    // relu
    do_reset();
    conf_knmask = 32'hF; out_rdy = 1'b1;
`ifdef PSUM_DRAIN_RELU_EN
    relu_exp = 8'h00;
`else
    relu_exp = 8'hF0;
`endif
    strobe(0, 8'hF0);
    tick();
    strobe(0, 8'h70);
    tick();
    sval = 4'h0;
    check_eq("relu_neg", 32'(out_data), 32'(relu_exp));
    tick();
    check_eq("relu_pos", 32'(out_data), 32'h70);
    tick();
    check_eq("relu_cnt", drain_cnt, 32'd2);

    // reset mid-operation
    out_rdy = 1'b0;
    for (int w = 0; w < 4; w++) begin
      strobe(0, 8'(8'h11 + w));
      tick();
    end
    sval = 4'h0;
    check_eq("mid_pre_val", 32'(out_val), 32'd1);
    check_eq("mid_pre_ovf", 32'(ovf), 32'h1);
    #3;
    rst = 1'b0;
    #1;
    check_eq("mid_val", 32'(out_val), 32'd0);
    check_eq("mid_busy", 32'(busy), 32'd0);
    check_eq("mid_ovf", 32'(ovf), 32'd0);
    check_eq("mid_cnt", drain_cnt, 32'd0);
    tick();
    rst = 1'b1;
    out_rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_eq($sformatf("mid_stale%0d", c), 32'(out_val), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
